execute_stage: RTL

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, ALU, branch/jump redirect, EX/MEM register
// and a multi-cycle restoring divider that stalls the front of the pipe.
//
// state | meaning
// IDLE  | no divide in flight; a DivE cycle stalls and latches operands
// BUSY  | one quotient bit per cycle, DATA_WIDTH cycles, stalled
// DONE  | result ready, EX/MEM loads it; DivE ignored this cycle
module execute_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWriteE,
    input  logic [1:0]            ResultSrcE,
    input  logic                  MemWriteE,
    input  logic                  JumpE,
    input  logic                  BranchE,
    input  logic [3:0]            ALUControlE,
    input  logic                  ALUSrcE,
    input  logic                  JALRInstrE,
    input  logic [2:0]            AddressingControlE,
    input  logic [DATA_WIDTH-1:0] RD1E,
    input  logic [DATA_WIDTH-1:0] RD2E,
    input  logic [DATA_WIDTH-1:0] PCE,
    input  logic [DATA_WIDTH-1:0] ExtImmE,
    input  logic [DATA_WIDTH-1:0] PCPlus4E,
    input  logic [4:0]            RdE,
    input  logic                  DivE,
    input  logic [1:0]            DivOpE,
    input  logic [1:0]            ForwardAE,
    input  logic [1:0]            ForwardBE,
    input  logic [DATA_WIDTH-1:0] ResultW,
    output logic                  PCSrcE,
    output logic [DATA_WIDTH-1:0] PCTargetE,
    output logic                  StallE,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic [1:0]            ResultSrcM,
    output logic [DATA_WIDTH-1:0] ALUResultM,
    output logic [DATA_WIDTH-1:0] WriteDataM,
    output logic [DATA_WIDTH-1:0] PCPlus4M,
    output logic [4:0]            RdM,
    output logic [2:0]            AddressingControlM
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

    div_state_t state, state_next;

    logic [DATA_WIDTH-1:0] src_a, write_data, src_b, alu_result, jalr_sum;
    logic                  taken;

    always_comb begin
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUResultM;
            default: src_a = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   write_data = ResultW;
            2'b10:   write_data = ALUResultM;
            default: write_data = RD2E;
        endcase
        src_b = ALUSrcE ? ExtImmE : write_data;
    end

    always_comb begin
        case (ALUControlE)
            4'b0000: alu_result = src_a + src_b;
            4'b0001: alu_result = src_a - src_b;
            4'b0010: alu_result = src_a & src_b;
            4'b0011: alu_result = src_a | src_b;
            4'b0100: alu_result = src_a ^ src_b;
            4'b0101: alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            4'b0110: alu_result = {{(DATA_WIDTH-1){1'b0}}, src_a < src_b};
            4'b0111: alu_result = src_a << src_b[4:0];
            4'b1000: alu_result = src_a >> src_b[4:0];
            4'b1001: alu_result = $signed(src_a) >>> src_b[4:0];
            4'b1010: alu_result = src_b;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        case (AddressingControlE)
            3'b000:  taken = (src_a == write_data);
            3'b001:  taken = (src_a != write_data);
            3'b100:  taken = ($signed(src_a) < $signed(write_data));
            3'b101:  taken = ($signed(src_a) >= $signed(write_data));
            3'b110:  taken = (src_a < write_data);
            3'b111:  taken = (src_a >= write_data);
            default: taken = 1'b0;
        endcase
        jalr_sum  = src_a + ExtImmE;
        PCTargetE = JALRInstrE ? {jalr_sum[DATA_WIDTH-1:1], 1'b0} : PCE + ExtImmE;
        PCSrcE    = ~StallE & (JumpE | (BranchE & taken));
    end

    // Divider datapath: operands held as magnitudes, sign fix-up applied in DONE.
    logic [DATA_WIDTH-1:0] div_a, div_b, dvs, quo, rem, rem_low, rem_next, div_result;
    logic [CW-1:0]         count;
    logic [1:0]            div_op;
    logic                  neg_a, neg_b, rem_ge, op_signed;

    assign op_signed = ~DivOpE[0];

    // Top bit of the shifted remainder is tracked separately so the compare
    // and subtract stay DATA_WIDTH wide.
    always_comb begin
        rem_low  = {rem[DATA_WIDTH-2:0], quo[DATA_WIDTH-1]};
        rem_ge   = rem[DATA_WIDTH-1] | (rem_low >= dvs);
        rem_next = rem_ge ? rem_low - dvs : rem_low;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_a  <= '0;
            div_b  <= '0;
            dvs    <= '0;
            quo    <= '0;
            rem    <= '0;
            count  <= '0;
            div_op <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
        end else if (state == S_IDLE && DivE) begin
            div_a  <= src_a;
            div_b  <= write_data;
            div_op <= DivOpE;
            neg_a  <= op_signed & src_a[DATA_WIDTH-1];
            neg_b  <= op_signed & write_data[DATA_WIDTH-1];
            quo    <= (op_signed & src_a[DATA_WIDTH-1]) ? -src_a : src_a;
            dvs    <= (op_signed & write_data[DATA_WIDTH-1]) ? -write_data : write_data;
            rem    <= '0;
            count  <= '0;
        end else if (state == S_BUSY) begin
            quo   <= {quo[DATA_WIDTH-2:0], rem_ge};
            rem   <= rem_next;
            count <= count + 1'b1;
        end
    end

    always_comb begin
        if (div_b == '0)
            div_result = div_op[1] ? div_a : '1;
        else if (div_op[1])
            div_result = (~div_op[0] & neg_a) ? -rem : rem;
        else
            div_result = (~div_op[0] & (neg_a ^ neg_b)) ? -quo : quo;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (DivE) state_next = S_BUSY;
            S_BUSY:  if (count == LAST_COUNT) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        StallE = (state == S_BUSY) | ((state == S_IDLE) & DivE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || StallE) begin
            RegWriteM          <= 1'b0;
            MemWriteM          <= 1'b0;
            ResultSrcM         <= '0;
            ALUResultM         <= '0;
            WriteDataM         <= '0;
            PCPlus4M           <= '0;
            RdM                <= '0;
            AddressingControlM <= '0;
        end else begin
            RegWriteM          <= RegWriteE;
            MemWriteM          <= MemWriteE;
            ResultSrcM         <= ResultSrcE;
            ALUResultM         <= (state == S_DONE) ? div_result : alu_result;
            WriteDataM         <= write_data;
            PCPlus4M           <= PCPlus4E;
            RdM                <= RdE;
            AddressingControlM <= AddressingControlE;
        end
    end

endmodule
